// File: rtl/cpu_pkg.sv
// cpu_pkg: register-file geometry and the writeback entry
// bundle shared by the writeback path.
package cpu_pkg;
  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 16;
  localparam int NUM_REGS   = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_queue_if.sv
// wb_queue_if: producer handshakes, register-file write port
// and forwarding lookups of the writeback queue.
interface wb_queue_if import cpu_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_dest;
  logic [DATA_W-1:0] mem_data;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              reg_write_en;
  logic [ADDR_W-1:0] reg_write_dest;
  logic [DATA_W-1:0] reg_write_data;
  logic [ADDR_W-1:0] fwd_addr_1;
  logic              fwd_hit_1;
  logic [DATA_W-1:0] fwd_data_1;
  logic [ADDR_W-1:0] fwd_addr_2;
  logic              fwd_hit_2;
  logic [DATA_W-1:0] fwd_data_2;
  logic [NUM_REGS-1:0] pending;
  logic [CW-1:0]     count;

  modport master (
    output mem_valid, mem_dest, mem_data,
    output alu_valid, alu_dest, alu_data,
    output fwd_addr_1, fwd_addr_2,
    input  mem_ready, alu_ready,
    input  reg_write_en, reg_write_dest, reg_write_data,
    input  fwd_hit_1, fwd_data_1,
    input  fwd_hit_2, fwd_data_2,
    input  pending, count
  );

  modport slave (
    input  mem_valid, mem_dest, mem_data,
    input  alu_valid, alu_dest, alu_data,
    input  fwd_addr_1, fwd_addr_2,
    output mem_ready, alu_ready,
    output reg_write_en, reg_write_dest, reg_write_data,
    output fwd_hit_1, fwd_data_1,
    output fwd_hit_2, fwd_data_2,
    output pending, count
  );
endinterface

// File: rtl/wb_queue_fifo_mem.sv
// wb_fifo_mem: entry ring with read/write pointers, occupancy
// count and a two-slot write port (slot 1 only with slot 0).
module wb_fifo_mem import cpu_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      en0,
  input  wb_entry_t e0,
  input  logic      en1,
  input  wb_entry_t e1,
  output wb_entry_t ents [DEPTH],
  output logic [$clog2(DEPTH)-1:0] rptr,
  output logic [$clog2(DEPTH):0]   cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wptr;
  logic          deq;
  logic [CW:0]   cnt_nxt;

  // The register file never stalls: head leaves whenever present.
  assign deq = |cnt;
  assign cnt_nxt = {1'b0, cnt} - (CW+1)'(deq)
                 + (CW+1)'(en0) + (CW+1)'(en1);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) ents[i] <= '0;
    end else begin
      if (en0) ents[wptr] <= e0;
      if (en1) ents[wptr + PW'(1)] <= e1;
      wptr <= wptr + PW'(en0) + PW'(en1);
      rptr <= rptr + PW'(deq);
      cnt  <= cnt_nxt[CW-1:0];
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    cnt_nxt <= (CW+1)'(DEPTH)
  );
endmodule

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback buffer owning the register-file
// write port, with dual enqueue and two forwarding lookups.
module wb_queue import cpu_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input logic       clk,
  input logic       rst,
  wb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic          mem_q, alu_q;
  logic          en0, en1;
  wb_entry_t     e0, e1, head;
  wb_entry_t     ents [DEPTH];
  logic [PW-1:0] rptr, idx;
  logic [CW-1:0] cnt, free;
  logic          wen;
  logic          hit1, hit2;
  logic [DATA_W-1:0] d1, d2;
  logic [ADDR_W-1:0] wdest;
  logic [NUM_REGS-1:0] pend;

  assign free = CW'(DEPTH) - cnt;

  // Readiness looks only at registered occupancy.
  assign bus.mem_ready = !rst && free >= CW'(1);
  assign bus.alu_ready = !rst && (free >= CW'(2) ||
                         (free >= CW'(1) && !bus.mem_valid));

  // r0 writes are accepted but dropped.
  assign mem_q = bus.mem_valid && bus.mem_ready && |bus.mem_dest;
  assign alu_q = bus.alu_valid && bus.alu_ready && |bus.alu_dest;

  always_comb begin
    e0  = '{dest: bus.alu_dest, data: bus.alu_data};
    e1  = '{dest: bus.alu_dest, data: bus.alu_data};
    en0 = mem_q || alu_q;
    en1 = mem_q && alu_q;
    if (mem_q) e0 = '{dest: bus.mem_dest, data: bus.mem_data};
  end

  wb_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .rst  (rst),
    .en0  (en0),
    .e0   (e0),
    .en1  (en1),
    .e1   (e1),
    .ents (ents),
    .rptr (rptr),
    .cnt  (cnt)
  );

  assign head  = ents[rptr];
  assign wen   = !rst && |cnt;
  assign wdest = wen ? head.dest : '0;

  assign bus.reg_write_en   = wen;
  assign bus.reg_write_dest = wdest;
  assign bus.reg_write_data = wen ? DATA_W'(head.data) : '0;
  assign bus.count          = cnt;

  // Walk head to tail so the newest match is the one kept.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    d1   = '0;
    d2   = '0;
    pend = '0;
    idx  = rptr;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr + PW'(k);
      if (CW'(k) < cnt) begin
        pend[ents[idx].dest] = 1'b1;
        if (ents[idx].dest == bus.fwd_addr_1) begin
          hit1 = 1'b1;
          d1   = ents[idx].data;
        end
        if (ents[idx].dest == bus.fwd_addr_2) begin
          hit2 = 1'b1;
          d2   = ents[idx].data;
        end
      end
    end
    pend[0] = 1'b0;
    if (rst || bus.fwd_addr_1 == '0) begin
      hit1 = 1'b0;
      d1   = '0;
    end
    if (rst || bus.fwd_addr_2 == '0) begin
      hit2 = 1'b0;
      d2   = '0;
    end
    if (rst) pend = '0;
  end

  assign bus.fwd_hit_1  = hit1;
  assign bus.fwd_data_1 = d1;
  assign bus.fwd_hit_2  = hit2;
  assign bus.fwd_data_2 = d2;
  assign bus.pending    = pend;
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed stimulus for wb_queue, checked each
// cycle against a queue-level model plus literal expectations.
module tb_wb_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_queue_if #(.DEPTH(DEPTH)) bus ();

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int max_q  = 0;
  wb_entry_t q[$];

  task automatic check(string name, logic [31:0] act,
                       logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  function automatic bit m_mready();
    return !rst && (DEPTH - q.size()) >= 1;
  endfunction

  function automatic bit m_aready();
    int f;
    f = DEPTH - q.size();
    return !rst && (f >= 2 || (f >= 1 && !bus.mem_valid));
  endfunction

  // Model state update at the active edge.
  always @(posedge clk) begin : model
    bit mr, ar;
    if (rst) begin
      q.delete();
    end else begin
      mr = m_mready();
      ar = m_aready();
      if (q.size() != 0) void'(q.pop_front());
      if (bus.mem_valid && mr && bus.mem_dest != 0)
        q.push_back('{dest: bus.mem_dest, data: bus.mem_data});
      if (bus.alu_valid && ar && bus.alu_dest != 0)
        q.push_back('{dest: bus.alu_dest, data: bus.alu_data});
    end
    if (q.size() > max_q) max_q = q.size();
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge clk) begin : cmp
    logic [7:0]  ep;
    logic        h1, h2;
    logic [15:0] f1, f2;
    ep = '0; h1 = 0; h2 = 0; f1 = '0; f2 = '0;
    if (!rst) begin
      foreach (q[i]) begin
        ep[q[i].dest] = 1'b1;
        if (bus.fwd_addr_1 != 0 && q[i].dest == bus.fwd_addr_1) begin
          h1 = 1; f1 = q[i].data;
        end
        if (bus.fwd_addr_2 != 0 && q[i].dest == bus.fwd_addr_2) begin
          h2 = 1; f2 = q[i].data;
        end
      end
    end
    check("m_mem_ready", bus.mem_ready, m_mready());
    check("m_alu_ready", bus.alu_ready, m_aready());
    check("m_count", bus.count, q.size());
    check("m_wen", bus.reg_write_en, !rst && q.size() != 0);
    check("m_pending", bus.pending, ep);
    check("m_fwd1", {bus.fwd_hit_1, bus.fwd_data_1}, {h1, f1});
    check("m_fwd2", {bus.fwd_hit_2, bus.fwd_data_2}, {h2, f2});
    if (!rst) begin
      if (q.size() != 0)
        check("m_wr", {bus.reg_write_dest, bus.reg_write_data},
              {q[0].dest, q[0].data});
      else
        check("m_wr_idle", {bus.reg_write_dest, bus.reg_write_data}, '0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    bus.mem_valid = 0; bus.mem_dest = '0; bus.mem_data = '0;
    bus.alu_valid = 0; bus.alu_dest = '0; bus.alu_data = '0;
  endtask

  initial begin
    int mi, ai;
    rst = 1'b1;
    idle();
    bus.fwd_addr_1 = 3'd3;
    bus.fwd_addr_2 = 3'd7;
    tick(); tick(); settle();
    check("rst_mem_ready", bus.mem_ready, 0);
    check("rst_alu_ready", bus.alu_ready, 0);
    check("rst_wen", bus.reg_write_en, 0);
    check("rst_pending", bus.pending, 0);
    check("rst_count", bus.count, 0);
    tick(); rst = 1'b0; settle();
    check("rel_ready", {bus.mem_ready, bus.alu_ready}, 2'b11);
    check("empty_fwd2", {bus.fwd_hit_2, bus.fwd_data_2}, 17'h0);

    // single ALU write
    tick();
    bus.alu_valid = 1; bus.alu_dest = 3'd3; bus.alu_data = 16'h1234;
    settle();
    check("t1_alu_ready", bus.alu_ready, 1);
    tick(); idle(); settle();
    check("t1_wr", {bus.reg_write_en, bus.reg_write_dest,
                    bus.reg_write_data}, {1'b1, 3'd3, 16'h1234});
    check("t1_pend", bus.pending, 8'h08);
    check("t1_count", bus.count, 1);
    tick(); settle();
    check("t1_after", {bus.reg_write_en, bus.pending, bus.count},
          {1'b0, 8'h00, 3'd0});

    // same-cycle pair to one register
    tick();
    bus.mem_valid = 1; bus.mem_dest = 3'd5; bus.mem_data = 16'hAAAA;
    bus.alu_valid = 1; bus.alu_dest = 3'd5; bus.alu_data = 16'h5555;
    bus.fwd_addr_1 = 3'd5;
    tick(); idle(); settle();
    check("t2_first", bus.reg_write_data, 16'hAAAA);
    check("t2_count", bus.count, 2);
    check("t2_fwd_a", {bus.fwd_hit_1, bus.fwd_data_1}, {1'b1, 16'h5555});
    tick(); settle();
    check("t2_second", bus.reg_write_data, 16'h5555);
    check("t2_fwd_b", {bus.fwd_hit_1, bus.fwd_data_1}, {1'b1, 16'h5555});
    tick(); settle();
    check("t2_drained", {bus.fwd_hit_1, bus.count}, 4'h0);

    // r0 write is swallowed
    tick();
    bus.alu_valid = 1; bus.alu_dest = 3'd0; bus.alu_data = 16'hFFFF;
    bus.fwd_addr_1 = 3'd0;
    settle();
    check("r0_ready", bus.alu_ready, 1);
    tick(); idle(); settle();
    check("r0_none", {bus.reg_write_en, bus.count, bus.fwd_hit_1}, 5'h0);

    // saturating burst, both ports every cycle
    mi = 0; ai = 0;
    bus.fwd_addr_1 = 3'd2;
    for (int i = 0; i < 12; i++) begin
      tick();
      bus.mem_valid = 1;
      bus.mem_dest  = 3'(mi % 7 + 1);
      bus.mem_data  = 16'h1000 + 16'(mi);
      bus.alu_valid = 1;
      bus.alu_dest  = 3'((ai + 3) % 7 + 1);
      bus.alu_data  = 16'h2000 + 16'(ai);
      settle();
      if (i == 2) begin
        check("burst_count", bus.count, 3);
        check("burst_ready", {bus.mem_ready, bus.alu_ready}, 2'b10);
      end
      if (bus.mem_ready) mi++;
      if (bus.alu_ready) ai++;
    end
    tick(); idle(); settle();
    repeat (5) tick();
    settle();
    check("burst_drain", bus.count, 0);
    check("burst_max", max_q, 3);

    // reset with three entries queued
    tick();
    bus.mem_valid = 1; bus.mem_dest = 3'd1; bus.mem_data = 16'h1111;
    bus.alu_valid = 1; bus.alu_dest = 3'd2; bus.alu_data = 16'h2222;
    tick();
    bus.mem_dest = 3'd3; bus.mem_data = 16'h3333;
    bus.alu_dest = 3'd4; bus.alu_data = 16'h4444;
    tick(); idle(); rst = 1'b1; settle();
    check("mid_count", bus.count, 3);
    check("mid_out", {bus.reg_write_en, bus.pending,
                      bus.mem_ready, bus.alu_ready}, 11'h0);
    tick(); rst = 1'b0; settle();
    check("post_rst", {bus.reg_write_en, bus.count, bus.pending},
          12'h0);
    check("post_ready", {bus.mem_ready, bus.alu_ready}, 2'b11);

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
